// File: rtl/demux_pkg.sv
// Shared definitions for the demux_router stream distributor.
// Optional broadcast support is selected by the DEMUX_BCAST_EN macro (see demux_router.sv).
package demux_pkg;

   localparam int DEFAULT_SWITCH_BITS = 1;
   localparam int DEFAULT_DATA_WIDTH  = 8;

   // Every output lane owns a two-entry buffer; one spare slot lets the
   // producer keep streaming while the consumer pops.
   localparam int LANE_DEPTH = 2;

   // Occupancy of one lane buffer, 0..LANE_DEPTH.
   typedef logic [1:0] lane_cnt_t;

   localparam lane_cnt_t LANE_FULL = lane_cnt_t'(LANE_DEPTH);

endpackage

// File: rtl/demux_lane_buf.sv
// One output lane of demux_router: a two-entry FIFO with registered storage.
// The head word is read straight from storage, so a word pushed at one edge is
// visible on data_out right after that edge.
module demux_lane_buf
   import demux_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
)(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  push,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  pop,
   output logic                  valid,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  full
);

   logic [DATA_WIDTH-1:0] mem [0:LANE_DEPTH-1];
   logic                  wr_ptr;
   logic                  rd_ptr;
   lane_cnt_t             count;
   logic                  push_ok;
   logic                  pop_ok;

   // Guard against writing a full buffer or reading an empty one.
   assign push_ok  = push & ~full;
   assign pop_ok   = pop & valid;

   assign full     = (count == LANE_FULL);
   assign valid    = (count != '0);
   assign data_out = mem[rd_ptr];

   // Storage, wrap-around pointers and occupancy; reset flushes everything.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < LANE_DEPTH; i++) begin
            mem[i] <= '0;
         end
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= '0;
      end else begin
         if (push_ok) begin
            mem[wr_ptr] <= data_in;
            wr_ptr      <= ~wr_ptr;
         end
         if (pop_ok) begin
            rd_ptr <= ~rd_ptr;
         end
         case ({push_ok, pop_ok})
            2'b10:   count <= count + lane_cnt_t'(1);
            2'b01:   count <= count - lane_cnt_t'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/demux_router.sv
// 1-to-N valid/ready stream demultiplexer. Each accepted word is routed to the
// lane named by in_sel and buffered in that lane's two-entry FIFO.
// Define DEMUX_BCAST_EN to add the in_bcast port, which pushes a word into all
// lanes at once when every lane has room.
module demux_router
   import demux_pkg::*;
#(
   parameter  int SWITCH_BITS = DEFAULT_SWITCH_BITS,
   parameter  int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
   localparam int N_CELL      = 1 << SWITCH_BITS
)(
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [SWITCH_BITS-1:0] in_sel,
   input  logic [DATA_WIDTH-1:0]  in_data,
`ifdef DEMUX_BCAST_EN
   input  logic                   in_bcast,
`endif
   output logic [N_CELL-1:0]      out_valid,
   input  logic [N_CELL-1:0]      out_ready,
   output logic [DATA_WIDTH-1:0]  out_data [0:N_CELL-1]
);

   logic [N_CELL-1:0] full;
   logic [N_CELL-1:0] push;
   logic [N_CELL-1:0] pop;
   logic              lane_ready;

   assign pop = out_valid & out_ready;

   // Acceptance looks only at registered lane fullness, so out_ready never
   // reaches in_ready combinationally; the selected lane (or all lanes for a
   // broadcast) gets the push.
   always_comb begin
      push       = '0;
      lane_ready = ~full[in_sel];
`ifdef DEMUX_BCAST_EN
      if (in_valid && in_bcast) begin
         lane_ready = ~|full;
      end
`endif
      in_ready = rst_n & lane_ready;
      if (in_valid && in_ready) begin
`ifdef DEMUX_BCAST_EN
         if (in_bcast) begin
            push = '1;
         end else begin
            push[in_sel] = 1'b1;
         end
`else
         push[in_sel] = 1'b1;
`endif
      end
   end

   for (genvar k = 0; k < N_CELL; k++) begin : g_lane
      demux_lane_buf #(
         .DATA_WIDTH (DATA_WIDTH)
      ) u_lane (
         .clk      (clk),
         .rst_n    (rst_n),
         .push     (push[k]),
         .data_in  (in_data),
         .pop      (pop[k]),
         .valid    (out_valid[k]),
         .data_out (out_data[k]),
         .full     (full[k])
      );
   end

endmodule

// File: tb/tb_demux_router.sv
// Self-checking bench for demux_router with four lanes (SWITCH_BITS=2).
// Expected behaviour comes from per-lane queues holding at most two words.
module tb_demux_router;

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [1:0] in_sel;
   logic [7:0] in_data;
   logic       in_bcast;
   logic [3:0] out_valid;
   logic [3:0] out_ready;
   logic [7:0] out_data [0:3];

   int checks = 0;
   int errors = 0;
   bit last_fire;

   logic [7:0] q [4][$];

   demux_router #(
      .SWITCH_BITS (2),
      .DATA_WIDTH  (8)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_sel    (in_sel),
      .in_data   (in_data),
`ifdef DEMUX_BCAST_EN
      .in_bcast  (in_bcast),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data)
   );

   // Free-running clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic bit exp_ready();
      bit all_room;
      if (!rst_n) return 1'b0;
      all_room = 1'b1;
      for (int k = 0; k < 4; k++) if (q[k].size() >= 2) all_room = 1'b0;
      if (in_valid && in_bcast) return all_room;
      return q[in_sel].size() < 2;
   endfunction

   function automatic logic [3:0] exp_valid();
      logic [3:0] v;
      for (int k = 0; k < 4; k++) v[k] = (q[k].size() != 0);
      return v;
   endfunction

   // Advance one clock and apply the same transfers to the reference queues.
   task automatic tick();
      bit fire;
      bit [3:0] popv;
      fire = in_valid && exp_ready();
      for (int k = 0; k < 4; k++) popv[k] = out_ready[k] && (q[k].size() != 0);
      @(posedge clk);
      for (int k = 0; k < 4; k++) if (popv[k]) void'(q[k].pop_front());
      if (fire) begin
         if (in_bcast) for (int k = 0; k < 4; k++) q[k].push_back(in_data);
         else q[in_sel].push_back(in_data);
      end
      last_fire = fire;
      #1;
   endtask

   task automatic drain();
      in_valid  = 1'b0;
      in_bcast  = 1'b0;
      out_ready = 4'hF;
      repeat (3) tick();
   endtask

   task automatic test_reset();
      #2;
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 4'b0) begin
         errors++;
         $display("[TB] FAIL reset_hold ready/valid got %b/%b expected 0/0000", in_ready, out_valid);
      end
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (out_data[k] !== 8'h00) begin
            errors++;
            $display("[TB] FAIL reset_data lane%0d got %h expected 00", k, out_data[k]);
         end
      end
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      out_ready = 4'b0;
      for (int i = 0; i < 2; i++) begin
         in_valid = 1'b1;
         in_sel   = 2'(i);
         in_data  = 8'(8'h30 + i);
         tick();
      end
      #2;
      rst_n = 1'b0;
      in_valid = 1'b1;
      in_sel = 2'd0;
      for (int k = 0; k < 4; k++) q[k].delete();
      #1;
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 4'b0) begin
         errors++;
         $display("[TB] FAIL reset_mid ready/valid got %b/%b expected 0/0000", in_ready, out_valid);
      end
      @(negedge clk);
      in_valid = 1'b0;
      rst_n = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 4'b0) begin
         errors++;
         $display("[TB] FAIL reset_release ready/valid got %b/%b expected 1/0000", in_ready, out_valid);
      end
      tick();
   endtask

   task automatic test_back_to_back();
      logic [7:0] words [2] = '{8'h11, 8'h22};
      logic [1:0] sels  [2] = '{2'd0, 2'd3};
      out_ready = 4'hF;
      for (int c = 0; c < 4; c++) begin
         in_valid = (c < 2);
         if (c < 2) begin
            in_sel  = sels[c];
            in_data = words[c];
         end
         #2;
         checks++;
         if (in_ready !== exp_ready()) begin
            errors++;
            $display("[TB] FAIL b2b_ready cyc%0d got %b expected %b", c, in_ready, exp_ready());
         end
         checks++;
         if (out_valid !== exp_valid()) begin
            errors++;
            $display("[TB] FAIL b2b_valid cyc%0d got %b expected %b", c, out_valid, exp_valid());
         end
         for (int k = 0; k < 4; k++) if (q[k].size() != 0) begin
            checks++;
            if (out_data[k] !== q[k][0]) begin
               errors++;
               $display("[TB] FAIL b2b_data lane%0d got %h expected %h", k, out_data[k], q[k][0]);
            end
         end
         if (c == 1) begin
            checks++;
            if (out_valid[0] !== 1'b1 || out_data[0] !== 8'h11) begin
               errors++;
               $display("[TB] FAIL b2b_lane0 got %b/%h expected 1/11", out_valid[0], out_data[0]);
            end
         end
         if (c == 2) begin
            checks++;
            if (out_valid[3] !== 1'b1 || out_data[3] !== 8'h22) begin
               errors++;
               $display("[TB] FAIL b2b_lane3 got %b/%h expected 1/22", out_valid[3], out_data[3]);
            end
         end
         tick();
      end
   endtask

   task automatic test_stall();
      logic [7:0] words [3] = '{8'hA1, 8'hA2, 8'hA3};
      int idx = 0;
      out_ready = 4'b1101;
      in_sel    = 2'd1;
      for (int c = 0; c < 12; c++) begin
         if (c == 5) out_ready = 4'hF;
         in_valid = (idx < 3);
         if (idx < 3) in_data = words[idx];
         #2;
         checks++;
         if (in_ready !== exp_ready()) begin
            errors++;
            $display("[TB] FAIL stall_ready cyc%0d got %b expected %b", c, in_ready, exp_ready());
         end
         if (c >= 2 && c < 5) begin
            checks++;
            if (in_ready !== 1'b0) begin
               errors++;
               $display("[TB] FAIL stall_full cyc%0d in_ready got %b expected 0", c, in_ready);
            end
         end
         checks++;
         if (out_valid !== exp_valid()) begin
            errors++;
            $display("[TB] FAIL stall_valid cyc%0d got %b expected %b", c, out_valid, exp_valid());
         end
         for (int k = 0; k < 4; k++) if (q[k].size() != 0) begin
            checks++;
            if (out_data[k] !== q[k][0]) begin
               errors++;
               $display("[TB] FAIL stall_data lane%0d got %h expected %h", k, out_data[k], q[k][0]);
            end
         end
         tick();
         if (last_fire) idx++;
      end
      checks++;
      if (idx !== 3) begin
         errors++;
         $display("[TB] FAIL stall_accept words got %0d expected 3", idx);
      end
      drain();
   endtask

   task automatic test_isolation();
      out_ready = 4'b1101;
      for (int c = 0; c < 10; c++) begin
         in_valid = 1'b1;
         in_sel   = (c < 2) ? 2'd1 : 2'd2;
         in_data  = 8'($urandom);
         #2;
         checks++;
         if (in_ready !== exp_ready()) begin
            errors++;
            $display("[TB] FAIL iso_ready cyc%0d got %b expected %b", c, in_ready, exp_ready());
         end
         if (c >= 2) begin
            checks++;
            if (in_ready !== 1'b1 || out_valid[1] !== 1'b1) begin
               errors++;
               $display("[TB] FAIL iso_lane2 cyc%0d ready/lane1 got %b/%b expected 1/1", c, in_ready, out_valid[1]);
            end
         end
         checks++;
         if (out_valid !== exp_valid()) begin
            errors++;
            $display("[TB] FAIL iso_valid cyc%0d got %b expected %b", c, out_valid, exp_valid());
         end
         for (int k = 0; k < 4; k++) if (q[k].size() != 0) begin
            checks++;
            if (out_data[k] !== q[k][0]) begin
               errors++;
               $display("[TB] FAIL iso_data lane%0d got %h expected %h", k, out_data[k], q[k][0]);
            end
         end
         tick();
      end
      drain();
   endtask

   task automatic test_push_pop();
      out_ready = 4'b0000;
      for (int c = 0; c < 10; c++) begin
         if (c == 1) out_ready = 4'b0001;
         in_valid = (c < 9);
         in_sel   = 2'd0;
         in_data  = 8'(8'h40 + c);
         #2;
         checks++;
         if (in_ready !== exp_ready()) begin
            errors++;
            $display("[TB] FAIL pp_ready cyc%0d got %b expected %b", c, in_ready, exp_ready());
         end
         checks++;
         if (out_valid !== exp_valid()) begin
            errors++;
            $display("[TB] FAIL pp_valid cyc%0d got %b expected %b", c, out_valid, exp_valid());
         end
         if (q[0].size() != 0) begin
            checks++;
            if (out_data[0] !== q[0][0]) begin
               errors++;
               $display("[TB] FAIL pp_data cyc%0d got %h expected %h", c, out_data[0], q[0][0]);
            end
         end
         tick();
      end
      drain();
   endtask

   task automatic test_random();
      last_fire = 1'b1;
      for (int c = 0; c < 400; c++) begin
         if (last_fire || !in_valid) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_sel   = 2'($urandom);
            in_data  = 8'($urandom);
         end
         out_ready = 4'($urandom);
         #2;
         checks++;
         if (in_ready !== exp_ready()) begin
            errors++;
            $display("[TB] FAIL rnd_ready cyc%0d got %b expected %b", c, in_ready, exp_ready());
         end
         checks++;
         if (out_valid !== exp_valid()) begin
            errors++;
            $display("[TB] FAIL rnd_valid cyc%0d got %b expected %b", c, out_valid, exp_valid());
         end
         for (int k = 0; k < 4; k++) if (q[k].size() != 0) begin
            checks++;
            if (out_data[k] !== q[k][0]) begin
               errors++;
               $display("[TB] FAIL rnd_data cyc%0d lane%0d got %h expected %h", c, k, out_data[k], q[k][0]);
            end
         end
         tick();
      end
      drain();
   endtask

`ifdef DEMUX_BCAST_EN
   task automatic test_bcast();
      out_ready = 4'b0000;
      for (int c = 0; c < 12; c++) begin
         if (c == 5) out_ready = 4'b0001;
         in_valid = (c < 2) || (c >= 2 && !q[1].size());
         in_bcast = (c >= 2);
         in_sel   = 2'd0;
         in_data  = (c < 2) ? 8'(8'h60 + c) : 8'h5A;
         #2;
         checks++;
         if (in_ready !== exp_ready()) begin
            errors++;
            $display("[TB] FAIL bc_ready cyc%0d got %b expected %b", c, in_ready, exp_ready());
         end
         if (c >= 2 && c < 5) begin
            checks++;
            if (in_ready !== 1'b0) begin
               errors++;
               $display("[TB] FAIL bc_blocked cyc%0d in_ready got %b expected 0", c, in_ready);
            end
         end
         checks++;
         if (out_valid !== exp_valid()) begin
            errors++;
            $display("[TB] FAIL bc_valid cyc%0d got %b expected %b", c, out_valid, exp_valid());
         end
         for (int k = 0; k < 4; k++) if (q[k].size() != 0) begin
            checks++;
            if (out_data[k] !== q[k][0]) begin
               errors++;
               $display("[TB] FAIL bc_data lane%0d got %h expected %h", k, out_data[k], q[k][0]);
            end
         end
         tick();
      end
      for (int k = 1; k < 4; k++) begin
         checks++;
         if (out_valid[k] !== 1'b1 || out_data[k] !== 8'h5A) begin
            errors++;
            $display("[TB] FAIL bc_lane%0d got %b/%h expected 1/5a", k, out_valid[k], out_data[k]);
         end
      end
      drain();
   endtask
`endif

   // Run every scenario in order, then report.
   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_sel    = 2'd0;
      in_data   = 8'h00;
      in_bcast  = 1'b0;
      out_ready = 4'b0000;
      last_fire = 1'b0;
      test_reset();
      test_back_to_back();
      test_stall();
      test_isolation();
      test_push_pop();
      test_random();
`ifdef DEMUX_BCAST_EN
      test_bcast();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
